// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-through, no-write-allocate L1 data cache with one
// 32-bit word per line. Load hits are answered combinationally in the same
// cycle. Load misses and all stores stall the pipeline while the backing
// memory is accessed over a req/ready handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   a                   byte address (ALUResult)
//   re / we             load / store request
//   writedata           store data
//   memop               funct3 of the load/store
//   readdata            sign/zero-extended load result (0 when no load)
//   stall               hold the pipeline; request must stay stable
//   mem_req             backing request valid (held until mem_ready)
//   mem_we              backing store (1) / word fetch (0)
//   mem_addr            backing byte address
//   mem_wdata           backing store data
//   mem_memop           backing memop (store memop, or 3'b010 on fetch)
//   mem_rdata           fetched word, valid with mem_ready
//   mem_ready           backing completes the request at this posedge
//   hit_count           load hit counter (wraps)
//   miss_count          load miss counter (wraps)
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] a,
    input  logic                     re,
    input  logic                     we,
    input  logic [DATA_WIDTH-1:0]    writedata,
    input  logic [2:0]               memop,
    output logic [DATA_WIDTH-1:0]    readdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_memop,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ready,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDRESS_WIDTH - 2 - IDX_W;
    localparam int HALF_W = 2 * BYTE_WIDTH;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [2:0]               mem_memop_q, mem_memop_d;
    logic [31:0]              hit_count_q, hit_count_d;
    logic [31:0]              miss_count_q, miss_count_d;
    logic [SETS-1:0]          valid_q, valid_d;

    // Line storage; tag and data carry no reset, only valid bits are cleared.
    logic [TAG_W-1:0]         tag_q  [SETS];
    logic [DATA_WIDTH-1:0]    data_q [SETS];

    // Line write port, shared by fills and store-hit merges.
    logic                     line_we;
    logic                     line_fill;
    logic [IDX_W-1:0]         line_idx;
    logic [TAG_W-1:0]         line_tag;
    logic [DATA_WIDTH-1:0]    line_data;
    logic [SETS-1:0]          line_wr;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]         req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic [1:0]               req_off;
    logic [IDX_W-1:0]         pend_idx;
    logic [TAG_W-1:0]         pend_tag;
    logic [1:0]               pend_off;

    assign req_idx  = a[2 +: IDX_W];
    assign req_tag  = a[ADDRESS_WIDTH-1 -: TAG_W];
    assign req_off  = a[1:0];
    assign pend_idx = mem_addr_q[2 +: IDX_W];
    assign pend_tag = mem_addr_q[ADDRESS_WIDTH-1 -: TAG_W];
    assign pend_off = mem_addr_q[1:0];

    logic is_store_op;
    logic is_load_op;
    logic req_hit;
    logic pend_hit;

    assign is_store_op = (memop == OP_B) || (memop == OP_H) || (memop == OP_W);
    assign is_load_op  = is_store_op || (memop == OP_BU) || (memop == OP_HU);
    assign req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign pend_hit    = valid_q[pend_idx] && (tag_q[pend_idx] == pend_tag);

    // ------------------------------------------------------------------
    // Little-endian lane extraction with sign/zero extension.
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            op
    );
        logic [BYTE_WIDTH-1:0] b;
        logic [HALF_W-1:0]     h;
        logic [DATA_WIDTH-1:0] r;
        b = word[off*BYTE_WIDTH +: BYTE_WIDTH];
        // Halves are aligned to a&~1, so only off[1] selects the lane.
        h = off[1] ? word[HALF_W +: HALF_W] : word[0 +: HALF_W];
        case (op)
            OP_B:    r = {{(DATA_WIDTH-BYTE_WIDTH){b[BYTE_WIDTH-1]}}, b};
            OP_BU:   r = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, b};
            OP_H:    r = {{(DATA_WIDTH-HALF_W){h[HALF_W-1]}}, h};
            OP_HU:   r = {{(DATA_WIDTH-HALF_W){1'b0}}, h};
            OP_W:    r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Merge store data into an existing cached word.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            off,
        input logic [2:0]            op
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        case (op)
            OP_B: r[off*BYTE_WIDTH +: BYTE_WIDTH] = wdata[BYTE_WIDTH-1:0];
            OP_H: begin
                if (off[1]) begin
                    r[HALF_W +: HALF_W] = wdata[HALF_W-1:0];
                end else begin
                    r[0 +: HALF_W] = wdata[HALF_W-1:0];
                end
            end
            OP_W:    r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_memop_d  = mem_memop_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        stall        = 1'b0;
        readdata     = '0;
        line_we      = 1'b0;
        line_fill    = 1'b0;
        line_idx     = pend_idx;
        line_tag     = pend_tag;
        line_data    = '0;

        case (state_q)
            IDLE: begin
                // Stores win over loads when both are requested.
                if (we && is_store_op) begin
                    stall       = 1'b1;
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = a;
                    mem_wdata_d = writedata;
                    mem_memop_d = memop;
                end else if (re) begin
                    if (!is_load_op) begin
                        readdata = DATA_WIDTH'(32'hdeadbeef);
                    end else if (req_hit) begin
                        readdata    = load_extract(data_q[req_idx], req_off, memop);
                        hit_count_d = hit_count_q + 32'd1;
                    end else begin
                        stall        = 1'b1;
                        miss_count_d = miss_count_q + 32'd1;
                        state_d      = FILL;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = {a[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_memop_d  = OP_W;
                    end
                end
            end

            FILL: begin
                stall = 1'b1;
                if (mem_ready) begin
                    line_we   = 1'b1;
                    line_fill = 1'b1;
                    line_data = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            WRITE: begin
                stall = 1'b1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    // Write-through: update the cached copy only on a hit.
                    if (pend_hit) begin
                        line_we   = 1'b1;
                        line_data = store_merge(data_q[pend_idx], mem_wdata_q,
                                                pend_off, mem_memop_q);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-line write decode and valid-bit update.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_line
        assign line_wr[gi] = line_we && (line_idx == IDX_W'(gi));
        assign valid_d[gi] = valid_q[gi] || (line_wr[gi] && line_fill);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_memop_q  <= 3'b000;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_memop_q  <= mem_memop_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
        end
    end

    // Line payload; a reset edge cannot coincide with a useful write since
    // the valid bits are cleared at that edge anyway.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SETS; i++) begin
            if (line_wr[i]) begin
                data_q[i] <= line_data;
                if (line_fill) begin
                    tag_q[i] <= line_tag;
                end
            end
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_memop  = mem_memop_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule
